// File: rtl/ex_gcd_resp_accum.sv
// Consumes a GCD result stream and emits one summary (sum, max, coprime count)
// for every NUM_RESULTS accepted results, over val/rdy handshakes on both sides.
module ex_gcd_resp_accum #(
    parameter int NUM_RESULTS = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_val,
    output logic        req_rdy,
    input  logic [15:0] req_result,
    output logic        resp_val,
    input  logic        resp_rdy,
    output logic [31:0] resp_sum,
    output logic [15:0] resp_max,
    output logic [15:0] resp_ncoprime
);

    localparam int CW = $clog2(NUM_RESULTS + 1);
    localparam logic [CW-1:0] LAST = CW'(NUM_RESULTS - 1);

    typedef enum logic {ACCUM, EMIT} state_t;

    state_t        state;
    state_t        state_next;
    logic [CW-1:0] count;
    logic [31:0]   sum;
    logic [15:0]   max_val;
    logic [15:0]   ncoprime;
    logic          req_xfer;
    logic          resp_xfer;

    always_comb begin
        state_next = state;
        req_rdy    = 1'b0;
        resp_val   = 1'b0;
        case (state)
            ACCUM: begin
                req_rdy = 1'b1;
                if (req_val && (count == LAST)) begin
                    state_next = EMIT;
                end
            end
            EMIT: begin
                resp_val = 1'b1;
                if (resp_rdy) begin
                    state_next = ACCUM;
                end
            end
            default: state_next = ACCUM;
        endcase
    end

    assign req_xfer  = req_val && req_rdy;
    assign resp_xfer = resp_val && resp_rdy;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ACCUM;
        end else begin
            state <= state_next;
        end
    end

    // Running totals stay live in ACCUM and freeze in EMIT until the summary is taken.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count    <= '0;
            sum      <= '0;
            max_val  <= '0;
            ncoprime <= '0;
        end else if (req_xfer) begin
            sum      <= sum + {16'd0, req_result};
            max_val  <= (req_result > max_val) ? req_result : max_val;
            ncoprime <= ncoprime + 16'((req_result == 16'd1) ? 1 : 0);
            count    <= (count == LAST) ? '0 : count + 1'b1;
        end else if (resp_xfer) begin
            sum      <= '0;
            max_val  <= '0;
            ncoprime <= '0;
        end
    end

    assign resp_sum      = sum;
    assign resp_max      = max_val;
    assign resp_ncoprime = ncoprime;

endmodule

// File: tb/tb_ex_gcd_resp_accum.sv
// Bench for ex_gcd_resp_accum: three instances (4, 1 and 256 results per group)
// fed from vector tables; summaries are checked against a scoreboard queue.
module tb_ex_gcd_resp_accum;

    typedef struct {
        int          inst;
        logic [31:0] sum;
        logic [15:0] max;
        logic [15:0] ncop;
    } exp_t;

    typedef struct {
        logic [3:0][15:0] r;
        logic [31:0]      sum;
        logic [15:0]      max;
        logic [15:0]      ncop;
    } vec_t;

    logic        clk;
    logic        reset;
    logic        req_val       [3];
    logic        req_rdy       [3];
    logic [15:0] req_result    [3];
    logic        resp_val      [3];
    logic        resp_rdy      [3];
    logic [31:0] resp_sum      [3];
    logic [15:0] resp_max      [3];
    logic [15:0] resp_ncoprime [3];
    int          sink_delay    [3];

    int compared;
    int mismatched;
    exp_t sb_q[$];

    logic        held_valid [3];
    logic [31:0] held_sum   [3];
    logic [15:0] held_max   [3];
    logic [15:0] held_ncop  [3];

    ex_gcd_resp_accum #(.NUM_RESULTS(4)) dut4 (
        .clk(clk), .reset(reset),
        .req_val(req_val[0]), .req_rdy(req_rdy[0]), .req_result(req_result[0]),
        .resp_val(resp_val[0]), .resp_rdy(resp_rdy[0]),
        .resp_sum(resp_sum[0]), .resp_max(resp_max[0]), .resp_ncoprime(resp_ncoprime[0])
    );

    ex_gcd_resp_accum #(.NUM_RESULTS(1)) dut1 (
        .clk(clk), .reset(reset),
        .req_val(req_val[1]), .req_rdy(req_rdy[1]), .req_result(req_result[1]),
        .resp_val(resp_val[1]), .resp_rdy(resp_rdy[1]),
        .resp_sum(resp_sum[1]), .resp_max(resp_max[1]), .resp_ncoprime(resp_ncoprime[1])
    );

    ex_gcd_resp_accum #(.NUM_RESULTS(256)) dut256 (
        .clk(clk), .reset(reset),
        .req_val(req_val[2]), .req_rdy(req_rdy[2]), .req_result(req_result[2]),
        .resp_val(resp_val[2]), .resp_rdy(resp_rdy[2]),
        .resp_sum(resp_sum[2]), .resp_max(resp_max[2]), .resp_ncoprime(resp_ncoprime[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic trace(input int i);
        $display("[TB] trace inst %0d emit sum=%0h max=%0h ncoprime=%0d",
                 i, resp_sum[i], resp_max[i], resp_ncoprime[i]);
    endtask

    // Offer one result after `gap` idle cycles; returns at posedge+1 after the transfer.
    task automatic applyStimulus(input int i, input logic [15:0] v, input int gap);
        int n;
        repeat (gap) begin
            @(posedge clk);
            #1;
        end
        req_val[i]    = 1'b1;
        req_result[i] = v;
        n = 0;
        while (!req_rdy[i] && n < 2000) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!req_rdy[i]) begin
            checkOutput("req_rdy_timeout", 32'(req_rdy[i]), 32'd1);
            req_val[i] = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        req_val[i] = 1'b0;
    endtask

    task automatic sendGroup4(input vec_t v, input int gap, input logic push);
        exp_t e;
        if (push) begin
            e.inst = 0;
            e.sum  = v.sum;
            e.max  = v.max;
            e.ncop = v.ncop;
            sb_q.push_back(e);
        end
        for (int k = 0; k < 4; k++) begin
            applyStimulus(0, v.r[k], gap);
            if (k == 2) checkOutput("val_before_last", 32'(resp_val[0]), 32'd0);
        end
        checkOutput("val_after_last", 32'(resp_val[0]), 32'd1);
    endtask

    function automatic vec_t mkVec(input logic [15:0] a, input logic [15:0] b,
                                   input logic [15:0] c, input logic [15:0] d,
                                   input logic [31:0] s, input logic [15:0] m,
                                   input logic [15:0] n);
        vec_t v;
        v.r[0] = a;
        v.r[1] = b;
        v.r[2] = c;
        v.r[3] = d;
        v.sum  = s;
        v.max  = m;
        v.ncop = n;
        return v;
    endfunction

    function automatic vec_t modelVec(input logic [15:0] a, input logic [15:0] b,
                                      input logic [15:0] c, input logic [15:0] d);
        vec_t v;
        v.r[0] = a;
        v.r[1] = b;
        v.r[2] = c;
        v.r[3] = d;
        v.sum  = 0;
        v.max  = 0;
        v.ncop = 0;
        for (int k = 0; k < 4; k++) begin
            v.sum = v.sum + 32'(v.r[k]);
            if (v.r[k] > v.max) v.max = v.r[k];
            if (v.r[k] == 16'd1) v.ncop = v.ncop + 16'd1;
        end
        return v;
    endfunction

    // Per-instance sink: hold resp_rdy low for sink_delay cycles of resp_val, then accept.
    for (genvar g = 0; g < 3; g++) begin : g_sink
        initial begin
            int wait_cnt;
            wait_cnt    = 0;
            resp_rdy[g] = 1'b0;
            forever begin
                @(posedge clk);
                #1;
                if (resp_val[g] && !resp_rdy[g]) begin
                    if (wait_cnt >= sink_delay[g]) resp_rdy[g] = 1'b1;
                    else wait_cnt++;
                end else begin
                    resp_rdy[g] = 1'b0;
                    wait_cnt    = 0;
                end
            end
        end
    end

    // Monitor: stability while stalled, and scoreboard compare on each summary transfer.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            for (int i = 0; i < 3; i++) begin
                if (reset && resp_val[i]) begin
                    checkOutput("req_rdy_in_emit", 32'(req_rdy[i]), 32'd0);
                    if (held_valid[i]) begin
                        checkOutput("hold_sum", resp_sum[i], held_sum[i]);
                        checkOutput("hold_max", 32'(resp_max[i]), 32'(held_max[i]));
                        checkOutput("hold_ncop", 32'(resp_ncoprime[i]), 32'(held_ncop[i]));
                    end
                    if (resp_rdy[i]) begin
                        held_valid[i] = 1'b0;
                        if (sb_q.size() == 0) begin
                            compared++;
                            mismatched++;
                            $display("[TB] FAIL unexpected_summary inst %0d: got sum %0h, required none",
                                     i, resp_sum[i]);
                        end else begin
                            e = sb_q.pop_front();
                            checkOutput("summary_inst", 32'(i), 32'(e.inst));
                            checkOutput("summary_sum", resp_sum[i], e.sum);
                            checkOutput("summary_max", 32'(resp_max[i]), 32'(e.max));
                            checkOutput("summary_ncop", 32'(resp_ncoprime[i]), 32'(e.ncop));
                            trace(i);
                        end
                    end else begin
                        held_valid[i] = 1'b1;
                        held_sum[i]   = resp_sum[i];
                        held_max[i]   = resp_max[i];
                        held_ncop[i]  = resp_ncoprime[i];
                    end
                end else begin
                    held_valid[i] = 1'b0;
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got no finish, required finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vec_t vecs[5];
        vec_t v;
        exp_t e;
        int   gaps[3];
        int   sinks[3];
        logic [15:0] one_vals[3];
        int   n;

        vecs[0] = mkVec(16'd3,  16'd7,  16'd5, 16'd1, 32'd16, 16'd7,  16'd1);
        vecs[1] = mkVec(16'd40, 16'd10, 16'd5, 16'd0, 32'd55, 16'd40, 16'd0);
        vecs[2] = mkVec(16'd0,  16'd0,  16'd0, 16'd0, 32'd0,  16'd0,  16'd0);
        vecs[3] = mkVec(16'd1,  16'd1,  16'd1, 16'd2, 32'd5,  16'd2,  16'd3);
        vecs[4] = mkVec(16'hffff, 16'd0, 16'd1, 16'hfffe, 32'h0001_fffe, 16'hffff, 16'd1);
        gaps     = '{0, 0, 5};
        sinks    = '{0, 10, 0};
        one_vals = '{16'd1, 16'd0, 16'd255};

        compared   = 0;
        mismatched = 0;
        reset      = 1'b0;
        for (int i = 0; i < 3; i++) begin
            req_val[i]    = 1'b0;
            req_result[i] = 16'd0;
            sink_delay[i] = 0;
            held_valid[i] = 1'b0;
        end

        #12;
        for (int i = 0; i < 3; i++) begin
            checkOutput("rst_req_rdy", 32'(req_rdy[i]), 32'd1);
            checkOutput("rst_resp_val", 32'(resp_val[i]), 32'd0);
            checkOutput("rst_sum", resp_sum[i], 32'd0);
            checkOutput("rst_max", 32'(resp_max[i]), 32'd0);
            checkOutput("rst_ncop", 32'(resp_ncoprime[i]), 32'd0);
        end
        @(posedge clk);
        #1;
        reset = 1'b1;

        // Table vectors under three source/sink timing scenarios.
        for (int s = 0; s < 3; s++) begin
            sink_delay[0] = sinks[s];
            for (int r = 0; r < 5; r++) sendGroup4(vecs[r], gaps[s], 1'b1);
        end
        sink_delay[0] = 0;

        // Random groups checked against the bench model.
        for (int r = 0; r < 6; r++) begin
            if (r[0]) v = modelVec(16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom));
            else      v = modelVec(16'($urandom_range(0, 3)), 16'($urandom_range(0, 3)),
                                   16'($urandom_range(0, 3)), 16'($urandom_range(0, 3)));
            sendGroup4(v, r % 3, 1'b1);
        end

        // Partial group persists across a long idle stretch.
        applyStimulus(0, 16'd9, 0);
        applyStimulus(0, 16'd1, 0);
        applyStimulus(0, 16'd4, 0);
        repeat (20) @(posedge clk);
        #1;
        checkOutput("idle_no_emit", 32'(resp_val[0]), 32'd0);
        e.inst = 0;
        e.sum  = 32'd20;
        e.max  = 16'd9;
        e.ncop = 16'd1;
        sb_q.push_back(e);
        applyStimulus(0, 16'd6, 0);
        checkOutput("idle_val_after_last", 32'(resp_val[0]), 32'd1);
        repeat (3) @(posedge clk);
        #1;

        // Reset after two results discards the partial group.
        applyStimulus(0, 16'd3, 0);
        applyStimulus(0, 16'd7, 0);
        reset = 1'b0;
        #1;
        checkOutput("midrst_sum", resp_sum[0], 32'd0);
        checkOutput("midrst_max", 32'(resp_max[0]), 32'd0);
        checkOutput("midrst_val", 32'(resp_val[0]), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        sendGroup4(mkVec(16'd1, 16'd1, 16'd1, 16'd1, 32'd4, 16'd1, 16'd4), 0, 1'b1);
        repeat (3) @(posedge clk);
        #1;

        // Reset while a summary is pending drops it.
        sink_delay[0] = 100000;
        sendGroup4(vecs[0], 0, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        checkOutput("emit_pending_val", 32'(resp_val[0]), 32'd1);
        reset = 1'b0;
        #1;
        checkOutput("emitrst_val", 32'(resp_val[0]), 32'd0);
        checkOutput("emitrst_rdy", 32'(req_rdy[0]), 32'd1);
        checkOutput("emitrst_sum", resp_sum[0], 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        sink_delay[0] = 0;
        sendGroup4(vecs[1], 0, 1'b1);

        // Single-result groups.
        for (int r = 0; r < 3; r++) begin
            e.inst = 1;
            e.sum  = 32'(one_vals[r]);
            e.max  = one_vals[r];
            e.ncop = (one_vals[r] == 16'd1) ? 16'd1 : 16'd0;
            sb_q.push_back(e);
            applyStimulus(1, one_vals[r], 0);
            checkOutput("n1_val_after", 32'(resp_val[1]), 32'd1);
        end

        // Full-size group of all-ones results.
        e.inst = 2;
        e.sum  = 32'h00ff_ff00;
        e.max  = 16'hffff;
        e.ncop = 16'd0;
        sb_q.push_back(e);
        for (int k = 0; k < 256; k++) begin
            applyStimulus(2, 16'hffff, 0);
            if (k == 254) checkOutput("n256_val_before_last", 32'(resp_val[2]), 32'd0);
        end
        checkOutput("n256_val_after_last", 32'(resp_val[2]), 32'd1);

        n = 0;
        while (sb_q.size() != 0 && n < 200) begin
            @(posedge clk);
            n++;
        end
        #1;
        checkOutput("scoreboard_drained", 32'(sb_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
